button_events: RTL and testbench

Multi-channel push-button front end for the 25 MHz game logic: raw, asynchronous, bouncing button inputs are synchronised, debounced and turned into one-cycle press, release and auto-repeat pulses. Each channel is independent, so one instance serves the whole button bank. Players and menu logic consume the pulses directly in the `clk25` domain, and `level` gives the held/not-held state.

---
 rtl/button_events.sv | 119 +++++++++++
 tb/tb_button_events.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/button_events.sv
// Multi-channel push-button front end: synchronise, debounce, and emit one-cycle
// press / release / auto-repeat pulses per channel. Channels share only clock and reset.
module button_events #(
    parameter int N_CH            = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic            clk25,
    input  logic            reset,
    input  logic [N_CH-1:0] button_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    localparam int CW   = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX < 1) ? 1 : $clog2(RMAX + 1);

    localparam logic [N_CH-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};
    localparam logic [CW-1:0]   DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   DB_ONE   = CW'(1);
    localparam logic [RW-1:0]   RD_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]   RP_LAST  = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0]   R_ONE    = RW'(1);
    localparam logic            RPT_EN   = (REPEAT_DELAY > 0) ? 1'b1 : 1'b0;

    logic [N_CH-1:0] sync1_q, sync1_d;
    logic [N_CH-1:0] sync2_q, sync2_d;
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] release_q, release_d;
    logic [N_CH-1:0] repeat_q, repeat_d;
    logic [N_CH-1:0] first_q, first_d;
    logic [CW-1:0]   cnt_q  [N_CH];
    logic [CW-1:0]   cnt_d  [N_CH];
    logic [RW-1:0]   rcnt_q [N_CH];
    logic [RW-1:0]   rcnt_d [N_CH];
    logic [N_CH-1:0] pressed_s;

    // Next-state logic for synchroniser, debounce counter and auto-repeat per channel
    always_comb begin
        sync1_d   = button_in;
        sync2_d   = sync1_q;
        pressed_s = sync2_q ^ RAW_IDLE;
        level_d   = level_q;
        press_d   = {N_CH{1'b0}};
        release_d = {N_CH{1'b0}};
        repeat_d  = {N_CH{1'b0}};
        first_d   = first_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        for (int i = 0; i < N_CH; i++) begin
            if (pressed_s[i] == level_q[i]) begin
                cnt_d[i] = {CW{1'b0}};
            end else if (cnt_q[i] == DB_LAST) begin
                cnt_d[i]     = {CW{1'b0}};
                level_d[i]   = pressed_s[i];
                press_d[i]   = pressed_s[i];
                release_d[i] = ~pressed_s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + DB_ONE;
            end

            // A release accepted on this edge wins over a repeat that would fire
            if (press_d[i]) begin
                rcnt_d[i]  = {RW{1'b0}};
                first_d[i] = 1'b1;
            end else if (!RPT_EN || !level_q[i]) begin
                rcnt_d[i] = {RW{1'b0}};
            end else if ((first_q[i] && (rcnt_q[i] == RD_LAST)) ||
                         (!first_q[i] && (rcnt_q[i] == RP_LAST))) begin
                rcnt_d[i]   = {RW{1'b0}};
                first_d[i]  = 1'b0;
                repeat_d[i] = ~release_d[i];
            end else begin
                rcnt_d[i] = rcnt_q[i] + R_ONE;
            end
        end
    end

    // State and output registers, asynchronously returned to the released state
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            sync1_q   <= RAW_IDLE;
            sync2_q   <= RAW_IDLE;
            level_q   <= {N_CH{1'b0}};
            press_q   <= {N_CH{1'b0}};
            release_q <= {N_CH{1'b0}};
            repeat_q  <= {N_CH{1'b0}};
            first_q   <= {N_CH{1'b0}};
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= {CW{1'b0}};
                rcnt_q[i] <= {RW{1'b0}};
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            first_q   <= first_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: a scoreboard of expected pulses keyed by edge number,
// checked every cycle, plus a second instance covering repeat-disabled, active-high, 1-cycle debounce.
module tb_button_events;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] b1 = 4'hF;
    logic [3:0] b2 = 4'h0;
    logic [3:0] level1, press1, rel1, rpt1;
    logic [3:0] level2, press2, rel2, rpt2;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;
    ev_t  sb[$];
    logic [3:0] exp_lvl = 4'h0;
    logic [3:0] ep, er, et;
    int   press2_n = 0, rel2_n = 0, rpt2_n = 0;

    button_events #(
        .N_CH(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) u_dut (
        .clk25(clk), .reset(reset), .button_in(b1),
        .level(level1), .press(press1), .release_pulse(rel1), .repeat_pulse(rpt1)
    );

    button_events #(
        .N_CH(4), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(1), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)
    ) u_norpt (
        .clk25(clk), .reset(reset), .button_in(b2),
        .level(level2), .press(press2), .release_pulse(rel2), .repeat_pulse(rpt2)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge number n, cyc == n
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic push(input int c, input int ch, input int kind);
        ev_t e;
        e.cyc  = c;
        e.ch   = ch;
        e.kind = kind;
        sb.push_back(e);
    endtask

    // Returns at the negedge just before edge e, so edge e samples what is driven next
    task automatic go(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    // Scoreboard monitor for the main instance
    always @(negedge clk) begin
        if (reset) begin
            exp_lvl = 4'h0;
        end else if (chk_en) begin
            ep = 4'h0;
            er = 4'h0;
            et = 4'h0;
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].cyc == cyc) begin
                    case (sb[k].kind)
                        0:       ep[sb[k].ch] = 1'b1;
                        1:       er[sb[k].ch] = 1'b1;
                        default: et[sb[k].ch] = 1'b1;
                    endcase
                    sb.delete(k);
                end
            end
            exp_lvl = (exp_lvl | ep) & ~er;
            check("press", {28'h0, press1}, {28'h0, ep});
            check("release", {28'h0, rel1}, {28'h0, er});
            check("repeat", {28'h0, rpt1}, {28'h0, et});
            check("level", {28'h0, level1}, {28'h0, exp_lvl});
        end
    end

    // Pulse tallies for the repeat-disabled instance
    always @(negedge clk) begin
        if (!reset) begin
            press2_n = press2_n + int'(press2[1]);
            rel2_n   = rel2_n + int'(rel2[1]);
            rpt2_n   = rpt2_n + $countones(rpt2);
        end
    end

    initial begin
        @(negedge clk);
        check("rst_level1", {28'h0, level1}, 32'h0);
        check("rst_pulses1", {20'h0, press1, rel1, rpt1}, 32'h0);
        check("rst_all2", {16'h0, level2, press2, rel2, rpt2}, 32'h0);
        go(4);
        reset  = 1'b0;
        chk_en = 1'b1;

        // ch3 fully pressed, ch0 half-counted, then async reset mid-bounce
        go(10);
        b1[3] = 1'b0;
        push(15, 3, 0);
        go(17);
        b1[0] = 1'b0;
        go(20);
        b1[3]  = 1'b1;
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("async_rst_level", {28'h0, level1}, 32'h0);
        check("async_rst_pulses", {20'h0, press1, rel1, rpt1}, 32'h0);
        go(22);
        reset  = 1'b0;
        chk_en = 1'b1;
        push(27, 0, 0);

        // Clean release and re-press on ch0, each released before its first repeat
        go(30);
        b1[0] = 1'b1;
        push(35, 0, 1);
        go(40);
        b1[0] = 1'b0;
        push(45, 0, 0);
        go(48);
        b1[0] = 1'b1;
        push(53, 0, 1);

        // Bounce on ch1: 2-cycle low runs never reach the 4-cycle threshold
        for (int k = 0; k < 10; k++) begin
            go(60 + 2 * k);
            b1[1] = (k % 2 == 0) ? 1'b0 : 1'b1;
        end

        // Auto-repeat on ch2; the release lands where the fourth repeat would fire
        go(90);
        b1[2] = 1'b0;
        push(95, 2, 0);
        push(105, 2, 2);
        push(108, 2, 2);
        push(111, 2, 2);
        go(109);
        b1[2] = 1'b1;
        push(114, 2, 1);

        // Simultaneous press on ch0/ch3 with a short glitch on ch0
        go(130);
        b1[0] = 1'b0;
        b1[3] = 1'b0;
        push(135, 0, 0);
        push(135, 3, 0);
        push(145, 0, 2);
        push(145, 3, 2);
        push(148, 0, 2);
        push(148, 3, 2);
        go(138);
        b1[0] = 1'b1;
        go(140);
        b1[0] = 1'b0;
        go(146);
        b1[0] = 1'b1;
        b1[3] = 1'b1;
        push(151, 0, 1);
        push(151, 3, 1);

        // Repeat-disabled instance: active-high pin, 2-edge latency, long hold
        go(170);
        b2[1] = 1'b1;
        go(172);
        check("d1_level_early", {28'h0, level2}, 32'h0);
        check("d1_press_early", {28'h0, press2}, 32'h0);
        @(negedge clk);
        check("d1_level", {28'h0, level2}, 32'h2);
        check("d1_press", {28'h0, press2}, 32'h2);
        go(280);
        b2[1] = 1'b0;
        go(283);
        check("d1_release", {28'h0, rel2}, 32'h2);
        check("d1_level_off", {28'h0, level2}, 32'h0);
        go(290);
        check("norpt_press_count", press2_n, 1);
        check("norpt_release_count", rel2_n, 1);
        check("norpt_repeat_count", rpt2_n, 0);

        go(300);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
